// File: rtl/csp_chan_pkg.sv
// Shared definitions for CSP channel building blocks.
//   CSP_DW_DEFAULT : default data width of channel ports
//   CSP_RST_ACTIVE : level of the asynchronous reset input that holds reset
//   csp_idx_w()    : width of an index able to address n ports (minimum 1)
package csp_chan_pkg;

    localparam int CSP_DW_DEFAULT = 32;
    localparam bit CSP_RST_ACTIVE = 1'b0;

    function automatic int csp_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   req    : one request bit per slot
//   ptr    : index of the slot granted last; search begins at ptr+1 (mod N)
//   any    : at least one request is set
//   winner : first requesting slot found, wrapping past N-1 back to 0
// Requests are rotated so the search start sits at bit 0, fixed-priority
// encoded, and the resulting offset is rotated back to a slot index.
module rr_priority_pick
    import csp_chan_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = csp_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    int           w_start;
    logic [N-1:0] w_rot;

    always_comb begin
        w_start = (int'(ptr) + 1) % N;
        w_rot   = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = req[(w_start + k) % N];
        end
        // Walk downwards so the lowest rotated offset is the last assignment.
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                winner = IW'((w_start + k) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/chan_rr_join.sv
// N-to-1 round-robin join of CSP channel write ports.
//   clk                   : clock, all state on rising edge
//   reset                 : asynchronous, active-low reset
//   p_write_data          : producer data, port i at [i*DW +: DW]
//   p_write_request       : producer i offers a word
//   p_write_valid         : port i can accept (its one-entry buffer is empty)
//   channel_write_data    : registered output word
//   channel_write_request : output register holds a word
//   channel_write_valid   : channel accepts the word
//   channel_grant_id      : source port of the word on channel_write_data
// Every input is buffered and the output is registered, so neither handshake
// combinationally depends on the other side.
module chan_rr_join
    import csp_chan_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = CSP_DW_DEFAULT,
    localparam int IW = csp_idx_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*DW-1:0] p_write_data,
    input  logic [N-1:0]    p_write_request,
    output logic [N-1:0]    p_write_valid,
    output logic [DW-1:0]   channel_write_data,
    output logic            channel_write_request,
    input  logic            channel_write_valid,
    output logic [IW-1:0]   channel_grant_id
);

    logic [N-1:0]  r_buf_full;
    logic [DW-1:0] r_buf [N];
    logic          r_out_full;
    logic [DW-1:0] r_out_data;
    logic [IW-1:0] r_grant_id;
    logic [IW-1:0] r_ptr;

    logic [N-1:0]  w_in_hs;
    logic          w_any;
    logic [IW-1:0] w_winner;
    logic          w_load;

    rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (r_buf_full),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_in_hs = p_write_request & ~r_buf_full;
    // Loading whenever the output slot frees up this edge removes any bubble.
    assign w_load  = (~r_out_full | channel_write_valid) & w_any;

    // A buffer cannot be captured and granted in the same edge: capture needs
    // it empty, a grant needs it full.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == CSP_RST_ACTIVE) begin
            r_buf_full <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_in_hs[i]) begin
                    r_buf[i]      <= p_write_data[i*DW +: DW];
                    r_buf_full[i] <= 1'b1;
                end else if (w_load && (w_winner == IW'(i))) begin
                    r_buf_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == CSP_RST_ACTIVE) begin
            r_out_full <= 1'b0;
            r_out_data <= '0;
            r_grant_id <= '0;
            r_ptr      <= IW'(N - 1);
        end else if (w_load) begin
            r_out_full <= 1'b1;
            r_out_data <= r_buf[w_winner];
            r_grant_id <= w_winner;
            r_ptr      <= w_winner;
        end else if (r_out_full && channel_write_valid) begin
            r_out_full <= 1'b0;
        end
    end

    assign p_write_valid         = ~r_buf_full;
    assign channel_write_request = r_out_full;
    assign channel_write_data    = r_out_data;
    assign channel_grant_id      = r_grant_id;

endmodule

// File: tb/tb_chan_rr_join.sv
module tb_chan_rr_join;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N*DW-1:0] p_write_data = '0;
    logic [N-1:0]    p_write_request = '0;
    logic [N-1:0]    p_write_valid;
    logic [DW-1:0]   channel_write_data;
    logic            channel_write_request;
    logic            channel_write_valid = 1'b1;
    logic [1:0]      channel_grant_id;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sq [N][$];
    logic [N-1:0] hs;
    int n_cmp  = 0;
    int n_fail = 0;

    chan_rr_join #(.N(N), .DW(DW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .p_write_data          (p_write_data),
        .p_write_request       (p_write_request),
        .p_write_valid         (p_write_valid),
        .channel_write_data    (channel_write_data),
        .channel_write_request (channel_write_request),
        .channel_write_valid   (channel_write_valid),
        .channel_grant_id      (channel_grant_id)
    );

    always #5 clk = ~clk;

    // Producer driver: handshakes judged at negedge, queues advanced after posedge.
    always begin
        @(negedge clk);
        hs = p_write_request & p_write_valid & {N{reset}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!reset) sq[i].delete();
            else if (hs[i] && sq[i].size() != 0) void'(sq[i].pop_front());
            if (sq[i].size() != 0) begin
                p_write_request[i]       = 1'b1;
                p_write_data[i*DW +: DW] = sq[i][0];
            end else begin
                p_write_request[i] = 1'b0;
            end
        end
    end

    // Scoreboard monitor: a word leaves whenever request & valid at the sample point.
    always @(negedge clk) begin
        if (reset && channel_write_request && channel_write_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got id %0d data %h, required no transfer",
                         channel_grant_id, channel_write_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (channel_grant_id !== e.id || channel_write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL out_word: got id %0d data %h, required id %0d data %h",
                             channel_grant_id, channel_write_data, e.id, e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push_word(input int p, input logic [31:0] w);
        exp_t e;
        sq[p].push_back(w);
        e.id   = 2'(p);
        e.data = w;
        exp_q.push_back(e);
    endtask

    // Rounds of round-robin order starting at port 'first', restricted to 'mask'.
    task automatic push_rr(input int first, input logic [N-1:0] mask, input int k, input int base);
        for (int r = 0; r < k; r++) begin
            for (int j = 0; j < N; j++) begin
                int p;
                p = (first + j) % N;
                if (mask[p]) push_word(p, 32'(p * 256 + base + r));
            end
        end
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d words still pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // reset values and idle behaviour
        @(negedge clk);
        chk("rst_req", 64'(channel_write_request), 64'd0);
        chk("rst_data", 64'(channel_write_data), 64'd0);
        chk("rst_gid", 64'(channel_grant_id), 64'd0);
        chk("rst_pvalid", 64'(p_write_valid), 64'hF);
        #2 reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_pvalid", 64'(p_write_valid), 64'hF);
            chk("idle_req", 64'(channel_write_request), 64'd0);
        end

        // single word from port 2: latency and one-cycle output
        push_word(2, 32'hA5);
        @(negedge clk);
        @(negedge clk);
        chk("p2_buf_full", 64'(p_write_valid), 64'hB);
        chk("p2_req_early", 64'(channel_write_request), 64'd0);
        @(negedge clk);
        chk("p2_req", 64'(channel_write_request), 64'd1);
        chk("p2_data", 64'(channel_write_data), 64'hA5);
        chk("p2_gid", 64'(channel_grant_id), 64'd2);
        chk("p2_pvalid_back", 64'(p_write_valid), 64'hF);
        @(negedge clk);
        chk("p2_req_done", 64'(channel_write_request), 64'd0);
        wait_drain("p2", 20);

        // clean reset so the pointer restarts at N-1
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // all four ports streaming: 0,1,2,3 rotation
        push_rr(0, 4'hF, 3, 0);
        wait_drain("all4", 100);

        // ports 0 and 3 only: strict alternation 0,3
        push_rr(0, 4'b1001, 3, 'h10);
        wait_drain("p03", 100);

        // stalled channel: one word in output, four buffered
        @(posedge clk);
        #1 channel_write_valid = 1'b0;
        @(negedge clk);
        push_word(0, 32'h020);
        push_word(1, 32'h120);
        push_word(2, 32'h220);
        push_word(3, 32'h320);
        push_word(0, 32'h021);
        repeat (20) @(negedge clk);
        chk("stall_pvalid", 64'(p_write_valid), 64'h0);
        chk("stall_req", 64'(channel_write_request), 64'd1);
        chk("stall_gid", 64'(channel_grant_id), 64'd0);
        chk("stall_data", 64'(channel_write_data), 64'h020);
        @(posedge clk);
        #1 channel_write_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_back_to_back", 64'(channel_write_request), 64'd1);
        end
        @(negedge clk);
        chk("drain_end", 64'(channel_write_request), 64'd0);
        wait_drain("stall", 20);

        // asynchronous reset in mid-stream (last grant was port 0)
        push_rr(1, 4'hF, 6, 'h30);
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_req", 64'(channel_write_request), 64'd0);
        chk("async_data", 64'(channel_write_data), 64'd0);
        chk("async_gid", 64'(channel_grant_id), 64'd0);
        chk("async_pvalid", 64'(p_write_valid), 64'hF);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        push_rr(0, 4'b1001, 1, 'h40);
        wait_drain("post_rst", 20);
        repeat (6) @(negedge clk);
        chk("final_idle", 64'(channel_write_request), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
